tx_rr_arbiter: RTL and testbench

//  Round-robin scheduler sharing one slow-side transmitter between NSRC requesters.

---
 rtl/tx_rr_arbiter.sv | 115 +++++++++++
 tb/tb_tx_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tx_rr_arbiter.sv
// Round-robin scheduler sharing one transmitter between NSRC requesters.
// Optional handshake timeout is built only when TX_ARB_TIMEOUT_EN is defined.
module tx_rr_arbiter #(
  parameter int NSRC     = 4,
  parameter int IDW      = 2,
  parameter int TIMEOUT  = 255,
  parameter int TOW      = 8,
  parameter int DATA_MSB = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NSRC-1:0]              src_vld,
  input  logic [NSRC*(DATA_MSB+1)-1:0] src_data,
  output logic [NSRC-1:0]              src_done,
  input  logic                         snt,
  output logic                         vi,
  output logic [DATA_MSB:0]            sdata,
  output logic                         busy,
  output logic [IDW-1:0]               gnt_id,
  output logic                         to_err
);

  localparam int W = DATA_MSB + 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick;
  logic            found;
  logic            vi_nx;
  logic            busy_nx;
  logic [NSRC-1:0] done_nx;

  // First requester at or after rr_ptr, wrapping modulo NSRC
  always_comb begin
    logic [IDW-1:0] ix;
    pick  = '0;
    found = 1'b0;
    ix    = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      ix = IDW'((32'(rr_ptr) + k) % NSRC);
      if (!found && src_vld[ix]) begin
        found = 1'b1;
        pick  = ix;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = LOAD;
      LOAD:    state_nx = WAIT;
      WAIT:    if (snt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    vi_nx   = (state == IDLE) && found;
    busy_nx = (state_nx != IDLE);
    done_nx = '0;
    if (state == WAIT && snt) done_nx[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      gnt_id   <= '0;
      sdata    <= '0;
      vi       <= 1'b0;
      src_done <= '0;
      busy     <= 1'b0;
    end else begin
      vi       <= vi_nx;
      busy     <= busy_nx;
      src_done <= done_nx;
      if (state == IDLE && found) begin
        gnt_id <= pick;
        sdata  <= src_data[32'(pick)*W +: W];
      end
      if (state == DONE)
        rr_ptr <= (32'(gnt_id) == NSRC - 1) ? '0 : gnt_id + 1'b1;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  logic [TOW-1:0] tmo_cnt;

  // LOAD always precedes WAIT, so clearing there is the WAIT-entry clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      to_err  <= 1'b0;
    end else begin
      if (state == LOAD)
        tmo_cnt <= '0;
      else if (state == WAIT && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == WAIT && tmo_cnt == TOW'(TIMEOUT))
        to_err <= 1'b1;
    end
  end
`else
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Directed self-checking bench for tx_rr_arbiter: vector table plus corner sequences.
module tb_tx_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  src_vld;
  logic [31:0] src_data;
  logic [3:0]  src_done;
  logic        snt;
  logic        vi;
  logic [7:0]  sdata;
  logic        busy;
  logic [1:0]  gnt_id;
  logic        to_err;

  int total = 0;
  int bad   = 0;

  tx_rr_arbiter #(
    .NSRC(4), .IDW(2), .TIMEOUT(10), .TOW(8), .DATA_MSB(7)
  ) dut (
    .clk(clk), .reset(reset), .src_vld(src_vld), .src_data(src_data),
    .src_done(src_done), .snt(snt), .vi(vi), .sdata(sdata), .busy(busy),
    .gnt_id(gnt_id), .to_err(to_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [1:0] gnt;
    logic [7:0] data;
    int         dly;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_vi(input string nm);
    for (int k = 0; k < 16 && vi !== 1'b1; k++) @(negedge clk);
    chk({nm, "_vi"}, 32'(vi), 1);
  endtask

  task automatic pulse_snt();
    snt = 1'b1;
    @(negedge clk);
    snt = 1'b0;
  endtask

  task automatic xfer(input vec_t v);
    src_vld = v.vld;
    wait_vi("xfer");
    chk("xfer_gnt", 32'(gnt_id), 32'(v.gnt));
    chk("xfer_sdata", 32'(sdata), 32'(v.data));
    chk("xfer_busy", 32'(busy), 1);
    for (int i = 0; i < v.dly; i++) begin
      @(negedge clk);
      chk("xfer_vi_low", 32'(vi), 0);
      chk("xfer_hold", 32'(sdata), 32'(v.data));
      chk("xfer_nodone", 32'(src_done), 0);
    end
    pulse_snt();
    chk("xfer_done", 32'(src_done), 32'(4'b0001 << v.gnt));
    src_vld = 4'b0000;
    @(negedge clk);
    chk("xfer_done_1cyc", 32'(src_done), 0);
    chk("xfer_idle", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b1111, 2'd0, 8'h05, 2};
    vecs[1]  = '{4'b1111, 2'd1, 8'h15, 3};
    vecs[2]  = '{4'b1111, 2'd2, 8'hA5, 1};
    vecs[3]  = '{4'b1111, 2'd3, 8'h35, 4};
    vecs[4]  = '{4'b1111, 2'd0, 8'h05, 2};
    vecs[5]  = '{4'b0100, 2'd2, 8'hA5, 6};
    vecs[6]  = '{4'b1000, 2'd3, 8'h35, 1};
    vecs[7]  = '{4'b1001, 2'd0, 8'h05, 2};
    vecs[8]  = '{4'b1001, 2'd3, 8'h35, 3};
    vecs[9]  = '{4'b0011, 2'd0, 8'h05, 1};
    vecs[10] = '{4'b0011, 2'd1, 8'h15, 2};

    reset    = 1'b1;
    src_vld  = 4'b0000;
    src_data = {8'h35, 8'hA5, 8'h15, 8'h05};
    snt      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vi", 32'(vi), 0);
    chk("rst_gnt", 32'(gnt_id), 0);
    chk("rst_sdata", 32'(sdata), 0);
    chk("rst_done", 32'(src_done), 0);
    chk("rst_toerr", 32'(to_err), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) xfer(vecs[i]);

    // stray snt while idle
    snt = 1'b1;
    @(negedge clk);
    snt = 1'b0;
    chk("stray_busy", 32'(busy), 0);
    chk("stray_vi", 32'(vi), 0);
    chk("stray_done", 32'(src_done), 0);
    @(negedge clk);
    chk("stray_done2", 32'(src_done), 0);

    // source 1 drops request and changes its word after the grant
    src_vld = 4'b0010;
    wait_vi("drop");
    chk("drop_gnt", 32'(gnt_id), 1);
    chk("drop_sdata", 32'(sdata), 32'h15);
    src_vld  = 4'b0000;
    src_data = {8'h35, 8'hA5, 8'hEE, 8'h05};
    repeat (3) begin
      @(negedge clk);
      chk("drop_hold", 32'(sdata), 32'h15);
    end
    pulse_snt();
    chk("drop_done", 32'(src_done), 32'b0010);
    @(negedge clk);
    src_data = {8'h35, 8'hA5, 8'h15, 8'h05};

    // reset mid-WAIT, with rr_ptr left at 2 by the previous slot
    src_vld = 4'b1000;
    wait_vi("mid");
    chk("mid_gnt", 32'(gnt_id), 3);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_gnt", 32'(gnt_id), 0);
    chk("abort_sdata", 32'(sdata), 0);
    chk("abort_vi", 32'(vi), 0);
    chk("abort_done", 32'(src_done), 0);
    src_vld = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", 32'(src_done), 0);
      chk("abort_idle", 32'(busy), 0);
    end
    xfer('{4'b0101, 2'd0, 8'h05, 2});

`ifdef TX_ARB_TIMEOUT_EN
    src_vld = 4'b0001;
    wait_vi("tmo");
    repeat (10) @(negedge clk);
    chk("tmo_early", 32'(to_err), 0);
    repeat (3) @(negedge clk);
    chk("tmo_set", 32'(to_err), 1);
    chk("tmo_still_busy", 32'(busy), 1);
    pulse_snt();
    chk("tmo_late_done", 32'(src_done), 32'b0001);
    src_vld = 4'b0000;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", 32'(to_err), 1);
`else
    chk("toerr_tied", 32'(to_err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
